// File: rtl/onewire_pkg.sv
// Shared definitions for the 1-Wire byte sequencer: control-register bit
// positions, command opcodes and sequencer FSM states.
package onewire_pkg;

    localparam int CTL_DAT = 0;
    localparam int CTL_RST = 1;
    localparam int CTL_OVD = 2;
    localparam int CTL_CYC = 3;

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        POLL,
        CHECK,
        NEXT,
        RESP
    } state_e;

endpackage

// File: rtl/onewire_seq.sv
// Expands one reset/write-byte/read-byte command into 1-Wire core register cycles.
// First core write 1 cycle after accept; no response back-pressure (rsp_valid is a strobe).
module onewire_seq
    import onewire_pkg::*;
#(
    parameter int   POLL_GAP = 4,
    parameter int   TIMEOUT  = 65535,
    parameter logic OVD      = 1'b0
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_data,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        rsp_error,
    output logic        owm_ren,
    output logic        owm_wen,
    output logic        owm_adr,
    output logic [31:0] owm_wdt,
    input  logic [31:0] owm_rdt,
    output logic        busy
);

    localparam logic [7:0]  GAP_LAST = 8'(POLL_GAP - 1);
    localparam logic [15:0] TMO      = 16'(TIMEOUT);
    // With no gap the WAIT state is skipped entirely so the poll follows at once.
    localparam state_e      AFTER_WR = (POLL_GAP == 0) ? POLL : WAIT;

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic        err_q, err_d;
    logic        pres_q, pres_d;

    logic unused_rdt;
    assign unused_rdt = ^{owm_rdt[31:4], owm_rdt[2:1]};

    assign busy    = (state_q != IDLE);
    assign owm_adr = 1'b0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= IDLE;
            op_q       <= OP_RESET;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            poll_cnt_q <= '0;
            gap_cnt_q  <= '0;
            err_q      <= 1'b0;
            pres_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            poll_cnt_q <= poll_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            err_q      <= err_d;
            pres_q     <= pres_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        poll_cnt_d = poll_cnt_q;
        gap_cnt_d  = '0;
        err_d      = err_q;
        pres_d     = pres_q;
        cmd_ready  = 1'b0;
        owm_wen    = 1'b0;
        owm_ren    = 1'b0;
        owm_wdt    = '0;
        rsp_valid  = 1'b0;
        rsp_data   = '0;
        rsp_error  = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d       = cmd_op;
                    shreg_d    = (cmd_op == OP_WRITE) ? cmd_data : 8'h00;
                    bit_cnt_d  = '0;
                    poll_cnt_d = '0;
                    pres_d     = 1'b0;
                    err_d      = (cmd_op == OP_RSVD);
                    state_d    = (cmd_op == OP_RSVD) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                owm_wen          = 1'b1;
                owm_wdt[CTL_OVD] = OVD;
                owm_wdt[CTL_RST] = (op_q == OP_RESET);
                // Read slots release the line (DAT=1) so the slave can pull it low.
                owm_wdt[CTL_DAT] = (op_q == OP_READ) ? 1'b1 : shreg_q[0];
                state_d          = AFTER_WR;
            end
            WAIT: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = POLL;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            POLL: begin
                owm_ren = 1'b1;
                if (poll_cnt_q != 16'hFFFF) begin
                    poll_cnt_d = poll_cnt_q + 16'd1;
                end
                state_d = CHECK;
            end
            CHECK: begin
                if (owm_rdt[CTL_CYC]) begin
                    if (poll_cnt_q == TMO) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = AFTER_WR;
                    end
                end else if (op_q == OP_RESET) begin
                    pres_d  = ~owm_rdt[CTL_DAT];
                    state_d = RESP;
                end else begin
                    shreg_d = {owm_rdt[CTL_DAT], shreg_q[7:1]};
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (bit_cnt_q == 3'd7) begin
                    state_d = RESP;
                end else begin
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    poll_cnt_d = '0;
                    state_d    = ISSUE;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_error = err_q;
                if (!err_q) begin
                    rsp_data = (op_q == OP_RESET) ? {7'b0, pres_q} : shreg_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_onewire_seq.sv
// Bench for onewire_seq: a wired-AND 1-Wire line/core model answers register
// traffic, and each scenario task checks responses against expectations.
module tb_onewire_seq;
    import onewire_pkg::*;

    localparam int   GAP  = 2;
    localparam int   TMO  = 5;
    localparam logic OVDP = 1'b0;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [7:0]  cmd_data = 8'd0;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_error;
    logic        owm_ren;
    logic        owm_wen;
    logic        owm_adr;
    logic [31:0] owm_wdt;
    logic [31:0] owm_rdt = '0;
    logic        busy;

    onewire_seq #(.POLL_GAP(GAP), .TIMEOUT(TMO), .OVD(OVDP)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
        .owm_ren(owm_ren), .owm_wen(owm_wen), .owm_adr(owm_adr),
        .owm_wdt(owm_wdt), .owm_rdt(owm_rdt), .busy(busy)
    );

    always #5 PCLK = ~PCLK;

    int n_pass = 0;
    int n_total = 0;

    // Line/core model configuration, written only by the stimulus process.
    int         busy_cfg = 0;
    logic       stuck_cfg = 1'b0;
    logic       presence_cfg = 1'b1;
    logic [7:0] slave_bits = 8'hFF;

    // Model/monitor state, written only by the negedge process.
    int          ncyc = 0, t_acc = 0, t_wen = -1, t_ren = -1, t_rsp = -1;
    int          slot = 0, wen_cnt = 0, ren_cnt = 0, rsp_cnt = 0, viol = 0, polls_left = 0;
    logic        result = 1'b0;
    logic [31:0] wdt_q[$];

    always @(negedge PCLK) begin
        ncyc++;
        if (!PRESETn) begin
            owm_rdt = '0;
            polls_left = 0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                t_acc = ncyc; t_wen = -1; t_ren = -1; t_rsp = -1;
                slot = 0; wen_cnt = 0; ren_cnt = 0; rsp_cnt = 0;
                wdt_q.delete();
            end
            if (owm_wen && owm_ren) viol++;
            if (cmd_ready && (owm_wen || owm_ren)) viol++;
            if (owm_wen) begin
                wen_cnt++;
                if (t_wen < 0) t_wen = ncyc;
                wdt_q.push_back(owm_wdt);
                polls_left = busy_cfg;
                if (owm_wdt[CTL_RST]) begin
                    result = ~presence_cfg;
                end else begin
                    result = owm_wdt[CTL_DAT] & slave_bits[slot & 7];
                    slot++;
                end
            end
            if (owm_ren) begin
                ren_cnt++;
                if (t_ren < 0) t_ren = ncyc;
                if (stuck_cfg || polls_left > 0) begin
                    owm_rdt = 32'h8;
                    polls_left--;
                end else begin
                    owm_rdt = {31'b0, result};
                end
            end
            if (rsp_valid) begin
                rsp_cnt++;
                t_rsp = ncyc;
            end
        end
    end

    function automatic logic [31:0] exp_wdt(input logic [1:0] op, input logic [7:0] d, input int i);
        logic [31:0] w;
        w = '0;
        w[CTL_OVD] = OVDP;
        if (op == OP_RESET) w[CTL_RST] = 1'b1;
        else if (op == OP_READ) w[CTL_DAT] = 1'b1;
        else w[CTL_DAT] = d[i];
        return w;
    endfunction

    task automatic send(input logic [1:0] op, input logic [7:0] d,
                        output logic [7:0] rd, output logic er, output logic got);
        int n;
        @(posedge PCLK); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge PCLK); #1; n++;
        end
        @(posedge PCLK); #1;
        cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_data = 8'($urandom);
        got = 1'b0; rd = '0; er = 1'b0; n = 0;
        while (!got && n < 4000) begin
            @(negedge PCLK); n++;
            if (rsp_valid) begin got = 1'b1; rd = rsp_data; er = rsp_error; end
        end
    endtask

    task automatic test_reset();
        #3;
        n_total++; if (cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready got %b want 1", cmd_ready); else n_pass++;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); else n_pass++;
        n_total++; if (rsp_error !== 1'b0) $display("FAIL rst_rsp_error got %b want 0", rsp_error); else n_pass++;
        n_total++; if (rsp_data !== 8'h00) $display("FAIL rst_rsp_data got %h want 00", rsp_data); else n_pass++;
        n_total++; if ({owm_ren, owm_wen} !== 2'b00) $display("FAIL rst_strobes got %b want 00", {owm_ren, owm_wen}); else n_pass++;
        n_total++; if (owm_wdt !== 32'h0) $display("FAIL rst_wdt got %h want 0", owm_wdt); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
        n_total++; if (owm_adr !== 1'b0) $display("FAIL rst_adr got %b want 0", owm_adr); else n_pass++;
        @(posedge PCLK); #1; PRESETn = 1'b1;
        repeat (2) @(posedge PCLK);
    endtask

    task automatic test_reset_presence();
        logic [7:0] rd; logic er, got;
        busy_cfg = 3; stuck_cfg = 1'b0; presence_cfg = 1'b1;
        send(OP_RESET, 8'hFF, rd, er, got);
        @(negedge PCLK);
        n_total++; if (got !== 1'b1) $display("FAIL op0_got got %b want 1", got); else n_pass++;
        n_total++; if (rd !== 8'h01) $display("FAIL op0_data got %h want 01", rd); else n_pass++;
        n_total++; if (er !== 1'b0) $display("FAIL op0_err got %b want 0", er); else n_pass++;
        n_total++; if (wen_cnt !== 1) $display("FAIL op0_wen_cnt got %0d want 1", wen_cnt); else n_pass++;
        n_total++; if (wdt_q.size() != 1 || wdt_q[0] !== 32'h2) $display("FAIL op0_wdt got %0d words want one 00000002", wdt_q.size()); else n_pass++;
        n_total++; if (ren_cnt !== 4) $display("FAIL op0_ren_cnt got %0d want 4", ren_cnt); else n_pass++;
        n_total++; if (t_wen - t_acc !== 1) $display("FAIL op0_wen_lat got %0d want 1", t_wen - t_acc); else n_pass++;
        n_total++; if (t_ren - t_wen !== GAP + 1) $display("FAIL op0_ren_lat got %0d want %0d", t_ren - t_wen, GAP + 1); else n_pass++;
        n_total++; if (cmd_ready !== 1'b1) $display("FAIL op0_ready_back got %b want 1", cmd_ready); else n_pass++;
        n_total++; if (rsp_cnt !== 1) $display("FAIL op0_rsp_cnt got %0d want 1", rsp_cnt); else n_pass++;
    endtask

    task automatic test_write_a5();
        logic [7:0] rd; logic er, got;
        logic [7:0] seq = 8'hA5;
        busy_cfg = 0; stuck_cfg = 1'b0; slave_bits = 8'hFF;
        send(OP_WRITE, seq, rd, er, got);
        @(negedge PCLK);
        n_total++; if (wdt_q.size() != 8) $display("FAIL wr_wen_cnt got %0d want 8", wdt_q.size()); else n_pass++;
        for (int i = 0; i < 8 && i < wdt_q.size(); i++) begin
            n_total++; if (wdt_q[i] !== exp_wdt(OP_WRITE, seq, i)) $display("FAIL wr_wdt[%0d] got %h want %h", i, wdt_q[i], exp_wdt(OP_WRITE, seq, i)); else n_pass++;
        end
        n_total++; if (!got || rd !== 8'hA5 || er !== 1'b0) $display("FAIL wr_rsp got v%b d%h e%b want v1 dA5 e0", got, rd, er); else n_pass++;
    endtask

    task automatic test_read();
        logic [7:0] rd; logic er, got;
        busy_cfg = 1; stuck_cfg = 1'b0; slave_bits = 8'h86;
        send(OP_READ, 8'h00, rd, er, got);
        @(negedge PCLK);
        n_total++; if (wdt_q.size() != 8) $display("FAIL rd_wen_cnt got %0d want 8", wdt_q.size()); else n_pass++;
        for (int i = 0; i < 8 && i < wdt_q.size(); i++) begin
            n_total++; if (wdt_q[i] !== 32'h1) $display("FAIL rd_wdt[%0d] got %h want 00000001", i, wdt_q[i]); else n_pass++;
        end
        n_total++; if (!got || rd !== 8'h86 || er !== 1'b0) $display("FAIL rd_rsp got v%b d%h e%b want v1 d86 e0", got, rd, er); else n_pass++;
        n_total++; if (ren_cnt !== 16) $display("FAIL rd_ren_cnt got %0d want 16", ren_cnt); else n_pass++;
    endtask

    task automatic test_timeout();
        logic [7:0] rd; logic er, got;
        stuck_cfg = 1'b1;
        send(OP_READ, 8'h00, rd, er, got);
        n_total++; if (!got || er !== 1'b1) $display("FAIL tmo_err got v%b e%b want v1 e1", got, er); else n_pass++;
        @(negedge PCLK);
        n_total++; if (cmd_ready !== 1'b1) $display("FAIL tmo_ready_back got %b want 1", cmd_ready); else n_pass++;
        n_total++; if (ren_cnt !== TMO) $display("FAIL tmo_ren_cnt got %0d want %0d", ren_cnt, TMO); else n_pass++;
        n_total++; if (wen_cnt !== 1) $display("FAIL tmo_wen_cnt got %0d want 1", wen_cnt); else n_pass++;
        stuck_cfg = 1'b0;
    endtask

    task automatic test_reserved();
        logic [7:0] rd; logic er, got;
        send(OP_RSVD, 8'h5A, rd, er, got);
        @(negedge PCLK);
        n_total++; if (!got || er !== 1'b1) $display("FAIL rsvd_err got v%b e%b want v1 e1", got, er); else n_pass++;
        n_total++; if (t_rsp - t_acc < 1 || t_rsp - t_acc > 2) $display("FAIL rsvd_lat got %0d want 1..2", t_rsp - t_acc); else n_pass++;
        n_total++; if (wen_cnt !== 0 || ren_cnt !== 0) $display("FAIL rsvd_bus got wen%0d ren%0d want 0 0", wen_cnt, ren_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] rd; logic er, got;
        int n;
        busy_cfg = 1; slave_bits = 8'hFF;
        @(posedge PCLK); #1;
        cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_data = 8'($urandom);
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (slot < 5 && n < 1000) begin @(negedge PCLK); n++; end
        n_total++; if (slot !== 5) $display("FAIL mid_reach_bit4 got slot %0d want 5", slot); else n_pass++;
        #2; PRESETn = 1'b0; #1;
        n_total++; if (cmd_ready !== 1'b1 || busy !== 1'b0) $display("FAIL mid_ready_busy got %b%b want 10", cmd_ready, busy); else n_pass++;
        n_total++; if ({owm_ren, owm_wen, rsp_valid, rsp_error} !== 4'b0) $display("FAIL mid_strobes got %b want 0000", {owm_ren, owm_wen, rsp_valid, rsp_error}); else n_pass++;
        n_total++; if (owm_wdt !== 32'h0 || rsp_data !== 8'h00) $display("FAIL mid_data got %h/%h want 0/0", owm_wdt, rsp_data); else n_pass++;
        repeat (3) @(posedge PCLK);
        #1; PRESETn = 1'b1;
        repeat (6) @(negedge PCLK);
        n_total++; if (rsp_cnt !== 0) $display("FAIL mid_no_rsp got %0d want 0", rsp_cnt); else n_pass++;
        busy_cfg = 0; presence_cfg = 1'b1;
        send(OP_RESET, 8'h00, rd, er, got);
        n_total++; if (!got || rd !== 8'h01 || er !== 1'b0) $display("FAIL mid_op0 got v%b d%h e%b want v1 d01 e0", got, rd, er); else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] rd, d, exp_d; logic er, got;
        logic [1:0] op;
        int nslot;
        for (int k = 0; k < 20; k++) begin
            op = 2'($urandom_range(0, 3));
            d = 8'($urandom);
            busy_cfg = $urandom_range(0, 3);
            presence_cfg = 1'($urandom);
            slave_bits = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            case (op)
                OP_RESET: begin exp_d = {7'b0, presence_cfg}; nslot = 1; end
                OP_WRITE: begin exp_d = d & slave_bits; nslot = 8; end
                OP_READ:  begin exp_d = slave_bits; nslot = 8; end
                default:  begin exp_d = 8'h00; nslot = 0; end
            endcase
            send(op, d, rd, er, got);
            @(negedge PCLK);
            n_total++; if (!got || er !== (op == OP_RSVD)) $display("FAIL rnd%0d_err op%0d got v%b e%b want v1 e%b", k, op, got, er, op == OP_RSVD); else n_pass++;
            if (op != OP_RSVD) begin
                n_total++; if (rd !== exp_d) $display("FAIL rnd%0d_data op%0d got %h want %h", k, op, rd, exp_d); else n_pass++;
                n_total++; if (t_wen - t_acc !== 1) $display("FAIL rnd%0d_wen_lat got %0d want 1", k, t_wen - t_acc); else n_pass++;
                for (int i = 0; i < nslot && i < wdt_q.size(); i++) begin
                    n_total++; if (wdt_q[i] !== exp_wdt(op, d, i)) $display("FAIL rnd%0d_wdt[%0d] got %h want %h", k, i, wdt_q[i], exp_wdt(op, d, i)); else n_pass++;
                end
            end
            n_total++; if (wen_cnt !== nslot || ren_cnt !== nslot * (busy_cfg + 1)) $display("FAIL rnd%0d_counts got wen%0d ren%0d want %0d %0d", k, wen_cnt, ren_cnt, nslot, nslot * (busy_cfg + 1)); else n_pass++;
            n_total++; if (rsp_cnt !== 1) $display("FAIL rnd%0d_rsp_cnt got %0d want 1", k, rsp_cnt); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_reset_presence();
        test_write_a5();
        test_read();
        test_timeout();
        test_reserved();
        test_reset_mid();
        test_random();
        n_total++; if (viol !== 0) $display("FAIL bus_protocol got %0d violations want 0", viol); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete, got %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
